// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises ICache fetches and LSB loads/stores onto the 8-bit RAM/IO bus, LSB first.
// Optional MEMCTRL_IO_BACKPRESSURE_EN holds IO-space stores while cannot_read is high.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  clr,
   input  logic [ADDR_WIDTH-1:0] addr_target,
   input  logic                  ic_flag,
   output logic [31:0]           ic_val,
   output logic                  ic_isok,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic                  ls_flag,
   input  logic                  ls_wr,
   input  logic [1:0]            ls_size,
   input  logic [31:0]           ls_wdata,
   output logic [31:0]           ls_rdata,
   output logic                  ls_isok,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [7:0]            mem_write,
   output logic                  is_write,
   input  logic                  cannot_read,
   input  logic [7:0]            mem_result
);
   typedef enum logic [2:0] {IDLE, IC_RD, LS_RD, LS_WR, DONE} state_t;
   state_t                  state, state_nx;
   logic [2:0]              cnt, cnt_nx, n_q;
   logic [ADDR_WIDTH-1:0]   addr_q, cur_a;
   logic [31:0]             wdata_q, asm_q, ic_q, ls_q;
   logic                    is_ls, rd, hold, issue, smp, done_ic, done_ls;
   always_comb begin
      cur_a = addr_q + ADDR_WIDTH'(cnt);
      rd = state == IC_RD || state == LS_RD;
`ifdef MEMCTRL_IO_BACKPRESSURE_EN
      hold = state == LS_WR && cur_a[17:16] == 2'b11 && cannot_read;
`else
      hold = 1'b0 & cannot_read;
`endif
      // reads take one extra cycle at the end to sample the last returned byte
      issue = rd ? cnt < n_q : state == LS_WR;
      smp = rd && cnt != 3'd0;
      mem_a = issue ? cur_a : '0;
      is_write = state == LS_WR && rdy && !hold;
      mem_write = state == LS_WR ? wdata_q[{cnt[1:0], 3'b000} +: 8] : 8'd0;
      done_ic = state == DONE && !is_ls && !clr;
      done_ls = state == DONE && is_ls;
      ic_isok = done_ic;
      ls_isok = done_ls;
      ic_val = done_ic ? asm_q : ic_q;
      ls_rdata = done_ls ? asm_q : ls_q;
   end
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      case (state)
         IDLE: begin
            cnt_nx = 3'd0;
            state_nx = ls_flag ? (ls_wr ? LS_WR : LS_RD) : (ic_flag && !clr) ? IC_RD : IDLE;
         end
         IC_RD: begin
            cnt_nx = cnt + 3'd1;
            state_nx = clr ? IDLE : cnt == n_q ? DONE : IC_RD;
         end
         LS_RD: begin
            cnt_nx = cnt + 3'd1;
            state_nx = cnt == n_q ? DONE : LS_RD;
         end
         LS_WR: begin
            cnt_nx = hold ? cnt : cnt + 3'd1;
            state_nx = !hold && cnt == n_q - 3'd1 ? DONE : LS_WR;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= 3'd0;
         n_q <= 3'd0;
         addr_q <= '0;
         wdata_q <= 32'd0;
         asm_q <= 32'd0;
         ic_q <= 32'd0;
         ls_q <= 32'd0;
         is_ls <= 1'b0;
      end else if (rdy) begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (state == IDLE) begin
            asm_q <= 32'd0;
            is_ls <= ls_flag;
            addr_q <= ls_flag ? ls_addr : addr_target;
            n_q <= !ls_flag ? 3'd4 : ls_size == 2'b00 ? 3'd1 : ls_size == 2'b01 ? 3'd2 : 3'd4;
            wdata_q <= ls_wdata;
         end else if (smp) begin
            asm_q <= asm_q | ({24'd0, mem_result} << {cnt[1:0] - 2'd1, 3'b000});
         end
         if (done_ic) ic_q <= asm_q;
         if (done_ls) ls_q <= asm_q;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, clr = 1'b0;
   logic [31:0] addr_target = '0, ls_addr = '0, ls_wdata = '0;
   logic        ic_flag = 1'b0, ls_flag = 1'b0, ls_wr = 1'b0, cannot_read = 1'b0;
   logic [1:0]  ls_size = '0;
   logic [31:0] ic_val, ls_rdata, mem_a;
   logic        ic_isok, ls_isok, is_write;
   logic [7:0]  mem_write, mem_result = '0;
   int          errors = 0, checks = 0;
   logic [7:0]  bus_mem [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];
   logic [39:0] wq [$];
   logic [31:0] rq [$];
   logic [31:0] last_ic = '0;

   mem_arbiter dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .addr_target(addr_target),
      .ic_flag(ic_flag), .ic_val(ic_val), .ic_isok(ic_isok), .ls_addr(ls_addr), .ls_flag(ls_flag),
      .ls_wr(ls_wr), .ls_size(ls_size), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_isok(ls_isok),
      .mem_a(mem_a), .mem_write(mem_write), .is_write(is_write), .cannot_read(cannot_read),
      .mem_result(mem_result));

   always #5 clk = ~clk;

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
   endfunction
   function automatic logic [7:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
   endfunction
   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // RAM/IO model: one-cycle read latency, frozen together with the core while rdy is low
   always @(posedge clk) begin
      if (rdy) begin
         if (is_write) begin
            bus_mem[mem_a] = mem_write;
            wq.push_back({mem_a, mem_write});
         end else if (mem_a != 32'd0) rq.push_back(mem_a);
         mem_result <= bus_rd(mem_a);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         bus_mem[a + k] = w[8*k +: 8];
         ref_mem[a + k] = w[8*k +: 8];
      end
   endtask

   // One request; the model expects completion after a fixed number of rdy-high cycles
   task automatic xact(input string tag, input bit ic, input logic [31:0] a, input bit wr,
                       input logic [1:0] sz, input logic [31:0] wd, input int rdy_pct,
                       input int stall_at, input int cr_n, output int cyc_n);
      int n, base, highs;
      bit seen;
      logic [31:0] exp;
      n = ic ? 4 : sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
      base = wr ? n + 1 : n + 2;
`ifdef MEMCTRL_IO_BACKPRESSURE_EN
      if (wr && a[17:16] == 2'b11) base += cr_n;
`endif
      exp = '0;
      for (int k = 0; k < n; k++) exp[8*k +: 8] = ref_rd(a + k);
      wq.delete();
      rq.delete();
      if (ic) begin
         addr_target = a;
         ic_flag = 1'b1;
      end else begin
         ls_addr = a;
         ls_wr = wr;
         ls_size = sz;
         ls_wdata = wd;
         ls_flag = 1'b1;
      end
      highs = 0;
      cyc_n = 0;
      seen = 1'b0;
      while (cyc_n < 200) begin
         if (ic ? ic_isok : ls_isok) begin
            seen = 1'b1;
            break;
         end
         rdy = (stall_at >= 0 && (cyc_n == stall_at || cyc_n == stall_at + 1)) ? 1'b0
               : ($urandom_range(99) >= rdy_pct);
         cannot_read = cyc_n >= 1 && cyc_n <= cr_n;
         if (rdy) highs++;
         cyc_n++;
         @(negedge clk);
      end
      chk({tag, " done"}, seen, 1);
      chk({tag, " lat"}, highs, base);
      rdy = 1'b1;
      cannot_read = 1'b0;
      ic_flag = 1'b0;
      ls_flag = 1'b0;
      if (wr) begin
         chk({tag, " nwr"}, wq.size(), n);
         if (wq.size() == n)
            for (int k = 0; k < n; k++) chk({tag, " wr"}, wq[k], {a + k, wd[8*k +: 8]});
         for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
      end else begin
         chk({tag, " data"}, ic ? ic_val : ls_rdata, exp);
         chk({tag, " nwr"}, wq.size(), 0);
         chk({tag, " nrd"}, rq.size(), n);
         if (rq.size() == n)
            for (int k = 0; k < n; k++) chk({tag, " rda"}, rq[k], a + k);
         if (ic) last_ic = exp;
      end
      @(negedge clk);
      chk({tag, " pulse"}, ic ? ic_isok : ls_isok, 0);
   endtask

   initial begin
      int c, ls_t, ic_t;
      logic [31:0] a, exp_ic;
      repeat (2) @(negedge clk);
      chk("rst bus", {mem_a, is_write, mem_write, ic_isok, ls_isok}, 0);
      chk("rst data", {ic_val, ls_rdata}, 0);
      rst = 1'b1;
      @(negedge clk);

      preload(32'h100, 32'h00000513);
      xact("t1 fetch", 1, 32'h100, 0, 2'b10, 0, 0, -1, 0, c);
      chk("t1 val", ic_val, 32'h00000513);
      chk("t1 cyc", c, 6);

      preload(32'h200, 32'hDEADBEEF);
      exp_ic = {ref_rd(32'h303), ref_rd(32'h302), ref_rd(32'h301), ref_rd(32'h300)};
      ls_addr = 32'h200; ls_wr = 1'b0; ls_size = 2'b10; ls_flag = 1'b1;
      addr_target = 32'h300; ic_flag = 1'b1;
      c = 0; ls_t = -1; ic_t = -1;
      while (c < 100 && ic_t < 0) begin
         @(negedge clk);
         c++;
         if (ls_isok) begin
            ls_t = c;
            ls_flag = 1'b0;
            chk("t2 ls data", ls_rdata, 32'hDEADBEEF);
         end
         if (ic_isok) begin
            ic_t = c;
            ic_flag = 1'b0;
            chk("t2 ic data", ic_val, exp_ic);
         end
      end
      chk("t2 ls lat", ls_t, 6);
      chk("t2 ic lat", ic_t, 13);
      last_ic = exp_ic;
      @(negedge clk);

      xact("t3 sth", 0, 32'h1002, 1, 2'b01, 32'h0000BEEF, 0, -1, 0, c);
      chk("t3 cyc", c, 3);
      xact("t3 ldh", 0, 32'h1002, 0, 2'b01, 0, 0, -1, 0, c);
      chk("t3 back", ls_rdata, 32'h0000BEEF);

      xact("t4 io st", 0, 32'h30000, 1, 2'b00, 32'h41, 0, -1, 3, c);
`ifdef MEMCTRL_IO_BACKPRESSURE_EN
      chk("t4 cyc", c, 5);
`else
      chk("t4 cyc", c, 2);
`endif
      xact("io ld", 0, 32'h30000, 0, 2'b00, 0, 0, -1, 0, c);
      chk("io ld val", ls_rdata, 32'h41);

      addr_target = 32'h40; ic_flag = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b1; ic_flag = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      chk("t5 idle", mem_a, 0);
      for (int i = 0; i < 6; i++) begin
         chk("t5 no isok", ic_isok, 0);
         @(negedge clk);
      end
      chk("t5 val held", ic_val, last_ic);
      xact("t5 fetch44", 1, 32'h44, 0, 2'b10, 0, 0, -1, 0, c);
      chk("t5 cyc", c, 6);

      preload(32'h500, 32'hCAFEF00D);
      xact("t6 stall", 0, 32'h500, 0, 2'b10, 0, 0, 3, 0, c);
      chk("t6 val", ls_rdata, 32'hCAFEF00D);
      chk("t6 cyc", c, 8);

      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = $urandom_range(2);
         a = ($urandom_range(7) == 0) ? 32'h30000 + $urandom_range(3) : 32'h100 + $urandom_range(32'hEFF);
         if (kind == 0) a = a & ~32'h3;
         xact($sformatf("rnd%0d", i), kind == 0, a, kind == 2, 2'($urandom_range(3)), $urandom,
              25, -1, 0, c);
      end

      ls_addr = 32'h200; ls_wr = 1'b0; ls_size = 2'b10; ls_flag = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid rst bus", {mem_a, is_write, mem_write, ic_isok, ls_isok}, 0);
      chk("mid rst data", {ic_val, ls_rdata}, 0);
      ls_flag = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
